fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 12 +
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input ready, rvalid, rdata);
    modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register, stall hold buffer
// and redirect/drop handling. Optional misaligned-target flag via FETCH_MISALIGN_CHK_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic                 id_valid,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc,
    output logic [31:0]          id_pc_plus4,
    output logic                 misalign
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] fetch_pc_r;
    logic [31:0] hold_buf_r;
    logic        id_valid_r;
    logic [31:0] id_instr_r;
    logic [31:0] id_pc_r;
    logic [31:0] id_pc_plus4_r;
    logic        imem_req_s;

    assign imem_req_s  = ~rst & (state_r == ST_REQ) & ~stall & ~redirect;
    assign imem.req    = imem_req_s;
    assign imem.addr   = pc_r;
    assign id_valid    = id_valid_r;
    assign id_instr    = id_instr_r;
    assign id_pc       = id_pc_r;
    assign id_pc_plus4 = id_pc_plus4_r;

    // Fetch FSM, PC, hold buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_REQ;
            pc_r          <= RESET_PC;
            fetch_pc_r    <= RESET_PC;
            hold_buf_r    <= 32'h0000_0000;
            id_valid_r    <= 1'b0;
            id_instr_r    <= 32'h0000_0000;
            id_pc_r       <= 32'h0000_0000;
            id_pc_plus4_r <= 32'h0000_0000;
        end else if (redirect) begin
            pc_r       <= {redirect_pc[31:2], 2'b00};
            id_valid_r <= 1'b0;
            hold_buf_r <= 32'h0000_0000;
            // A response arriving alongside the redirect is the one in flight, so it
            // is consumed here rather than waited for in DROP.
            case (state_r)
                ST_REQ:  state_r <= ST_REQ;
                ST_WAIT: state_r <= imem.rvalid ? ST_REQ : ST_DROP;
                ST_HOLD: state_r <= ST_REQ;
                ST_DROP: state_r <= imem.rvalid ? ST_REQ : ST_DROP;
                default: state_r <= ST_REQ;
            endcase
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (imem_req_s && imem.ready) begin
                        fetch_pc_r <= pc_r;
                        state_r    <= ST_WAIT;
                    end
                    if (!stall) begin
                        id_valid_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (imem.rvalid && !stall) begin
                        id_valid_r    <= 1'b1;
                        id_instr_r    <= imem.rdata;
                        id_pc_r       <= fetch_pc_r;
                        id_pc_plus4_r <= pc_plus4(fetch_pc_r);
                        pc_r          <= pc_plus4(fetch_pc_r);
                        state_r       <= ST_REQ;
                    end else if (imem.rvalid) begin
                        hold_buf_r <= imem.rdata;
                        state_r    <= ST_HOLD;
                    end else if (!stall) begin
                        id_valid_r <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        id_valid_r    <= 1'b1;
                        id_instr_r    <= hold_buf_r;
                        id_pc_r       <= fetch_pc_r;
                        id_pc_plus4_r <= pc_plus4(fetch_pc_r);
                        pc_r          <= pc_plus4(fetch_pc_r);
                        state_r       <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem.rvalid) begin
                        state_r <= ST_REQ;
                    end
                    if (!stall) begin
                        id_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_REQ;
                    id_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_r;

    // One-cycle pulse after a redirect to a non-word-aligned target.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= redirect & (redirect_pc[1:0] != 2'b00);
        end
    end

    assign misalign = misalign_r;
`else
    logic misalign_unused_s;
    assign misalign_unused_s = |redirect_pc[1:0];
    assign misalign          = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage plus a short stall/latency sequence.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        misalign;

    int errors = 0;
    int checks = 0;

`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic MIS_EN = 1'b1;
`else
    localparam logic MIS_EN = 1'b0;
`endif

    fetch_stage_if imem_bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem_bus.master),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rdata;
        logic        stall, redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        idv, chk_id;
        logic [31:0] instr, idpc, idp4;
        logic        mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic st, input logic rd, input logic [31:0] rpc,
                       input logic req, input logic [31:0] addr, input logic idv, input logic chk_id,
                       input logic [31:0] instr, input logic [31:0] idpc, input logic [31:0] idp4,
                       input logic mis);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.stall = st; v.redir = rd; v.rpc = rpc;
        v.req = req; v.addr = addr; v.idv = idv; v.chk_id = chk_id;
        v.instr = instr; v.idpc = idpc; v.idp4 = idp4; v.mis = mis;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: actual=%h required=%h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rdata,
                         input logic st, input logic rd, input logic [31:0] rpc);
        rst = r; imem_bus.ready = rdy; imem_bus.rvalid = rv; imem_bus.rdata = rdata;
        stall = st; redirect = rd; redirect_pc = rpc;
    endtask

    initial begin
        logic got;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);

        // rst rdy rv rdata stall redir rpc | req addr idv chk instr idpc idp4 mis
        add(1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b0,1'b1,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b1,1'b1,32'h00500093,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,1'b1,32'h00500093,32'h0,32'h4,1'b0);
        add(1'b0,1'b1,1'b1,32'h00A00113,1'b0,1'b0,32'h0,        1'b0,32'h4,        1'b0,1'b0,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,32'h8,        1'b1,1'b1,32'h00A00113,32'h4,32'h8,1'b0);
        add(1'b0,1'b1,1'b1,32'h12345678,1'b1,1'b0,32'h0,        1'b0,32'h8,        1'b0,1'b1,32'h00A00113,32'h4,32'h8,1'b0);
        add(1'b0,1'b1,1'b0,32'h0,       1'b1,1'b0,32'h0,        1'b0,32'h8,        1'b0,1'b1,32'h00A00113,32'h4,32'h8,1'b0);
        add(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h8,        1'b0,1'b1,32'h00A00113,32'h4,32'h8,1'b0);
        add(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,32'hC,        1'b1,1'b1,32'h12345678,32'h8,32'hC,1'b0);
        add(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1,32'h100,      1'b0,32'hC,        1'b0,1'b0,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h100,      1'b0,1'b0,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b1,1'b1,32'hDEADBEEF,1'b0,1'b0,32'h0,        1'b0,32'h100,      1'b0,1'b0,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,32'h100,      1'b0,1'b0,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b0,1'b1,32'h00000013,1'b0,1'b0,32'h0,        1'b0,32'h100,      1'b0,1'b0,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,32'h104,      1'b1,1'b1,32'h00000013,32'h100,32'h104,1'b0);
        add(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b1,32'h102,      1'b0,32'h104,      1'b0,1'b0,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,32'h100,      1'b0,1'b0,32'h0,32'h0,32'h0,1'b1);
        add(1'b0,1'b0,1'b1,32'h11111111,1'b0,1'b1,32'hFFFFFFFC, 1'b0,32'h100,      1'b0,1'b0,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,32'hFFFFFFFC, 1'b0,1'b0,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b0,1'b1,32'h22222222,1'b0,1'b0,32'h0,        1'b0,32'hFFFFFFFC, 1'b0,1'b0,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b1,1'b1,32'h22222222,32'hFFFFFFFC,32'h0,1'b0);
        add(1'b0,1'b0,1'b1,32'h33333333,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,1'b1,32'h33333333,32'h0,32'h4,1'b0);
        add(1'b1,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,32'h4,        1'b0,1'b0,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b0,1'b1,32'h44444444,1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b0,1'b1,32'h0,32'h0,32'h0,1'b0);
        add(1'b0,1'b0,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b0,1'b0,32'h0,32'h0,32'h0,1'b0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rdata,
                  vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            #1;
            chk("imem_req",  i, {31'd0, imem_bus.req}, {31'd0, vecs[i].req});
            chk("imem_addr", i, imem_bus.addr,         vecs[i].addr);
            chk("id_valid",  i, {31'd0, id_valid},     {31'd0, vecs[i].idv});
            chk("misalign",  i, {31'd0, misalign},     {31'd0, vecs[i].mis & MIS_EN});
            if (vecs[i].chk_id) begin
                chk("id_instr",    i, id_instr,    vecs[i].instr);
                chk("id_pc",       i, id_pc,       vecs[i].idpc);
                chk("id_pc_plus4", i, id_pc_plus4, vecs[i].idp4);
            end
        end

        // Stall while id_valid=1: IF/ID holds and no request is issued.
        @(negedge clk); drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            #1;
            chk("stall_req",   100 + k, {31'd0, imem_bus.req}, 32'd0);
            chk("stall_valid", 100 + k, {31'd0, id_valid},     32'd1);
            chk("stall_instr", 100 + k, id_instr,              32'h55555555);
        end
        @(negedge clk); drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("unstall_req",  110, {31'd0, imem_bus.req}, 32'd1);
        chk("unstall_addr", 110, imem_bus.addr,         32'h4);

        // Slow memory: response two cycles late, then bounded wait for delivery.
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk); drive(1'b0, 1'b0, 1'b1, 32'h66666666, 1'b0, 1'b0, 32'h0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!got) begin
                #1;
                if (id_valid) got = 1'b1;
                else @(negedge clk);
            end
        end
        chk("slow_delivered", 120, {31'd0, got}, 32'd1);
        chk("slow_instr",     121, id_instr,     32'h66666666);
        chk("slow_pc",        122, id_pc,        32'h4);
        chk("slow_pc_plus4",  123, id_pc_plus4,  32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
